// File: rtl/oarr_clone_pkg.sv
// ---------------------------------------------------------------------------
// oarr_clone_pkg
//
// Shared types, default sizes and the round-robin pick helper used by the
// element-copy scheduler (oarr_clone_sched) and its arbiter
// (oarr_rr_arbiter).
//
// Contents:
//   state_e      - scheduler FSM states (IDLE, COPY, VERIFY, DONE)
//   DEF_NUM_REQ  - default number of requesters
//   DEF_DEPTH    - default elements per array
//   DEF_WIDTH    - default bits per element
//   MAX_REQ      - largest requester count the pick helper handles
//   rr_pick()    - one-hot round-robin selection starting at a pointer
//
// The VERIFY state is only entered when OARR_CLONE_VERIFY_EN is defined;
// the enum always carries it so every build shares one state encoding.
// ---------------------------------------------------------------------------
package oarr_clone_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COPY   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DEPTH   = 6;
  localparam int DEF_WIDTH   = 4;
  localparam int MAX_REQ     = 8;

  // Walk the request vector starting at ptr, wrapping at n, and return a
  // one-hot vector marking the first set bit found. Requests are held in a
  // fixed MAX_REQ-wide vector so the helper is independent of the caller's
  // requester count; bits at or above n are never looked at.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int                 idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < int'(n)) begin
        idx = int'(ptr) + i;
        if (idx >= int'(n)) begin
          idx = idx - int'(n);
        end
        if (!found && req[idx[2:0]]) begin
          gnt[idx[2:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/oarr_clone_sched_arbiter.sv
// ---------------------------------------------------------------------------
// oarr_rr_arbiter
//
// Purely combinational round-robin arbiter for the copy scheduler.
//
// Parameters:
//   NUM_REQ - number of requesters (2..8)
//   PTR_W   - width of the round-robin pointer / granted index
//
// Ports:
//   req_i   [NUM_REQ-1:0] - request vector
//   ptr_i   [PTR_W-1:0]   - requester that has highest priority this pick
//   gnt_o   [NUM_REQ-1:0] - one-hot pick (all zero when no request)
//   idx_o   [PTR_W-1:0]   - binary index of the picked requester
//   valid_o               - high when some requester was picked
// ---------------------------------------------------------------------------
module oarr_rr_arbiter
  import oarr_clone_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] pick;

  assign req_ext = MAX_REQ'(req_i);
  assign pick    = rr_pick(req_ext, 3'(ptr_i), NUM_REQ);
  assign gnt_o   = pick[NUM_REQ-1:0];
  assign valid_o = |pick;

  // Turn the one-hot pick into a binary index so the scheduler can later
  // advance its pointer to the requester just after the one it served.
  always_comb begin
    idx_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick[k]) begin
        idx_o = PTR_W'(k);
      end
    end
  end

endmodule

// File: rtl/oarr_clone_sched.sv
// ---------------------------------------------------------------------------
// oarr_clone_sched
//
// Round-robin scheduler sharing one element-copy datapath among NUM_REQ
// requesters. The granted requester's DEPTH-element source array is copied
// into the shared target array one element per cycle, then a done pulse is
// returned to that requester. Dropping req mid-copy aborts the transfer.
//
// Build option:
//   OARR_CLONE_VERIFY_EN - when defined, a VERIFY pass re-reads the source
//                          after the copy and flags any case-inequality on
//                          err (sticky until the next grant). When not
//                          defined there is no VERIFY pass and err is 0.
//
// Parameters:
//   NUM_REQ (2..8), DEPTH (>=1), WIDTH
//
// Ports:
//   clk      - clock, all state on the rising edge
//   rst_n    - asynchronous active-low reset
//   req      [NUM_REQ]       - level requests, held until done/abort
//   src_elem [NUM_REQ*WIDTH] - slice k is requester k's element at rd_idx
//   gnt      [NUM_REQ]       - one-hot grant, held for the whole transfer
//   rd_idx   [clog2(DEPTH)]  - element index being copied / verified
//   busy                     - high whenever the FSM is not IDLE
//   copied   [DEPTH*WIDTH]   - target array, element i at [i*WIDTH +: WIDTH]
//   done     [NUM_REQ]       - one-cycle completion pulse
//   abort    [NUM_REQ]       - one-cycle pulse when a granted req drops
//   err                      - verify mismatch flag
// ---------------------------------------------------------------------------
module oarr_clone_sched
  import oarr_clone_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int DEPTH   = DEF_DEPTH,
  parameter  int WIDTH   = DEF_WIDTH,
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] src_elem,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [IDX_W-1:0]         rd_idx,
  output logic                     busy,
  output logic [DEPTH*WIDTH-1:0]   copied,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       abort,
  output logic                     err
);

  // Reject configurations the datapath cannot represent.
  if (DEPTH < 1 || NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_param_check
    $error("oarr_clone_sched: need DEPTH >= 1 and 2 <= NUM_REQ <= 8");
  end

  state_e                   state_q, state_d;
  logic [NUM_REQ-1:0]       gnt_q, gnt_d;
  logic [NUM_REQ-1:0]       done_q, done_d;
  logic [NUM_REQ-1:0]       abort_q, abort_d;
  logic [PTR_W-1:0]         gidx_q, gidx_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;
  logic [DEPTH*WIDTH-1:0]   copied_q, copied_d;
  logic                     err_q, err_d;

  logic [NUM_REQ-1:0]       pick_gnt;
  logic [PTR_W-1:0]         pick_idx;
  logic                     pick_valid;
  logic [PTR_W-1:0]         next_ptr;
  logic [WIDTH-1:0]         sel_elem;
  logic                     req_held;
  logic                     last_elem;

  oarr_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // The granted requester's current element, routed by the one-hot grant
  // so X/Z bits on the source pass through to the target untouched.
  always_comb begin
    sel_elem = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_q[k]) begin
        sel_elem = src_elem[k*WIDTH +: WIDTH];
      end
    end
  end

`ifdef OARR_CLONE_VERIFY_EN
  logic [WIDTH-1:0] cur_elem;

  // Target element currently addressed by rd_idx, used by the verify pass.
  always_comb begin
    cur_elem = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx_q == IDX_W'(i)) begin
        cur_elem = copied_q[i*WIDTH +: WIDTH];
      end
    end
  end
`endif

  // The transfer survives only while the granted requester keeps req high.
  // After a transfer ends, priority moves to the requester just past the
  // one served, which is what keeps contending requesters fair.
  assign req_held  = |(req & gnt_q);
  assign last_elem = (rd_idx_q == IDX_W'(DEPTH - 1));
  assign next_ptr  = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);

  // Next-state logic. done/abort default to zero so they only ever pulse
  // for the single cycle after the transition that raised them.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    rd_idx_d = rd_idx_q;
    copied_d = copied_q;
    done_d   = '0;
    abort_d  = '0;
`ifdef OARR_CLONE_VERIFY_EN
    err_d    = err_q;
`else
    err_d    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d    = pick_gnt;
          gidx_d   = pick_idx;
          rd_idx_d = '0;
          err_d    = 1'b0;
          state_d  = COPY;
        end
      end

      COPY: begin
        if (!req_held) begin
          abort_d  = gnt_q;
          gnt_d    = '0;
          rd_idx_d = '0;
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx_q == IDX_W'(i)) begin
              copied_d[i*WIDTH +: WIDTH] = sel_elem;
            end
          end
          if (last_elem) begin
            rd_idx_d = '0;
`ifdef OARR_CLONE_VERIFY_EN
            state_d  = VERIFY;
`else
            state_d  = DONE;
`endif
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end

`ifdef OARR_CLONE_VERIFY_EN
      VERIFY: begin
        if (!req_held) begin
          abort_d  = gnt_q;
          gnt_d    = '0;
          rd_idx_d = '0;
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end else begin
          if (sel_elem !== cur_elem) begin
            err_d = 1'b1;
          end
          if (last_elem) begin
            rd_idx_d = '0;
            state_d  = DONE;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
`endif

      DONE: begin
        done_d   = gnt_q;
        gnt_d    = '0;
        rr_ptr_d = next_ptr;
        state_d  = IDLE;
      end

      default: begin
        gnt_d    = '0;
        rd_idx_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  // State register. Reset drops any transfer in flight with no pulses and
  // hands highest priority back to requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      rd_idx_q <= '0;
      copied_q <= '0;
      done_q   <= '0;
      abort_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      rd_idx_q <= rd_idx_d;
      copied_q <= copied_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
    end
  end

  assign gnt    = gnt_q;
  assign rd_idx = rd_idx_q;
  assign busy   = (state_q != IDLE);
  assign copied = copied_q;
  assign done   = done_q;
  assign abort  = abort_q;
  assign err    = err_q;

endmodule

// File: tb/tb_oarr_clone_sched.sv
// ---------------------------------------------------------------------------
// tb_oarr_clone_sched
//
// Self-checking bench for oarr_clone_sched at default sizes. A reference
// model tracks the round-robin pointer, the expected target array and the
// expected latency; requester sources are random except where a directed
// step needs specific values. Honours OARR_CLONE_VERIFY_EN for latency and
// err expectations.
// ---------------------------------------------------------------------------
module tb_oarr_clone_sched;

  localparam int NUM_REQ = 4;
  localparam int DEPTH   = 6;
  localparam int WIDTH   = 4;
  localparam int IDX_W   = 3;
`ifdef OARR_CLONE_VERIFY_EN
  localparam int       LAT     = 2 * DEPTH + 2;
  localparam bit       EXP_ERR = 1'b1;
`else
  localparam int       LAT     = DEPTH + 2;
  localparam bit       EXP_ERR = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rstN;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] srcElem;
  logic [NUM_REQ-1:0]       gnt;
  logic [IDX_W-1:0]         rdIdx;
  logic                     busy;
  logic [DEPTH*WIDTH-1:0]   copied;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       abort;
  logic                     err;

  logic [WIDTH-1:0] srcMem    [NUM_REQ][DEPTH];
  logic [WIDTH-1:0] expCopied [DEPTH];
  int               expPtr;
  int               checks = 0;
  int               errors = 0;

  oarr_clone_sched #(
    .NUM_REQ (NUM_REQ),
    .DEPTH   (DEPTH),
    .WIDTH   (WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rstN),
    .req      (req),
    .src_elem (srcElem),
    .gnt      (gnt),
    .rd_idx   (rdIdx),
    .busy     (busy),
    .copied   (copied),
    .done     (done),
    .abort    (abort),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Requesters answer the read index combinationally from their arrays.
  always_comb begin
    srcElem = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (int'(rdIdx) < DEPTH) begin
        srcElem[k*WIDTH +: WIDTH] = srcMem[k][rdIdx];
      end
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r);
    req = r;
  endtask

  task automatic randomizeSrc(input int k);
    for (int i = 0; i < DEPTH; i++) begin
      srcMem[k][i] = 4'($urandom_range(0, 15));
    end
  endtask

  function automatic logic [DEPTH*WIDTH-1:0] packCopied();
    logic [DEPTH*WIDTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v[i*WIDTH +: WIDTH] = expCopied[i];
    end
    return v;
  endfunction

  // Reference arbitration: first requesting index at or after ptr, wrapping.
  function automatic int rrPick(input logic [NUM_REQ-1:0] r, input int ptr);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r[(ptr + i) % NUM_REQ]) begin
        return (ptr + i) % NUM_REQ;
      end
    end
    return -1;
  endfunction

  // Count negedges until a done or abort pulse is seen, with a bound.
  task automatic waitEvent(output int cyc, output logic [NUM_REQ-1:0] firstGnt);
    cyc      = 0;
    firstGnt = '0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) firstGnt = gnt;
      if ((done | abort) != '0) break;
    end
  endtask

  // Let the model-chosen requester complete a full transfer and check it.
  task automatic serveOne(input string tag);
    int                 g;
    int                 cyc;
    logic [NUM_REQ-1:0] fg;
    logic [NUM_REQ-1:0] oneHot;
    g              = rrPick(req, expPtr);
    oneHot         = '0;
    oneHot[g]      = 1'b1;
    waitEvent(cyc, fg);
    for (int i = 0; i < DEPTH; i++) expCopied[i] = srcMem[g][i];
    checkOutput({tag, "_gnt"},    64'(fg),     64'(oneHot));
    checkOutput({tag, "_lat"},    64'(cyc),    64'(LAT));
    checkOutput({tag, "_done"},   64'(done),   64'(oneHot));
    checkOutput({tag, "_abort"},  64'(abort),  64'(0));
    checkOutput({tag, "_busy"},   64'(busy),   64'(0));
    checkOutput({tag, "_err"},    64'(err),    64'(0));
    checkOutput({tag, "_copied"}, 64'(copied), 64'(packCopied()));
    req[g] = 1'b0;
    expPtr = (g + 1) % NUM_REQ;
    randomizeSrc(g);
  endtask

  initial begin
    int                 g0;
    int                 k;
    int                 cyc;
    logic [NUM_REQ-1:0] fg;
    logic [NUM_REQ-1:0] oneHot;
    logic [WIDTH-1:0]   xVal;

    rstN   = 1'b0;
    req    = '0;
    expPtr = 0;
    for (int i = 0; i < DEPTH; i++) expCopied[i] = '0;
    for (int j = 0; j < NUM_REQ; j++) randomizeSrc(j);

    // Reset values while reset is held.
    #2;
    checkOutput("rst_gnt",    64'(gnt),    64'(0));
    checkOutput("rst_rdIdx",  64'(rdIdx),  64'(0));
    checkOutput("rst_busy",   64'(busy),   64'(0));
    checkOutput("rst_copied", 64'(copied), 64'(0));
    checkOutput("rst_done",   64'(done),   64'(0));
    checkOutput("rst_abort",  64'(abort),  64'(0));
    checkOutput("rst_err",    64'(err),    64'(0));
    @(negedge clk);
    rstN = 1'b1;

    // Single requester with a known ramp of values.
    for (int i = 0; i < DEPTH; i++) srcMem[0][i] = 4'(3 + i);
    @(negedge clk);
    $display("[TB] single requester");
    applyStimulus(4'b0001);
    serveOne("single");

    // All requesters at once; the first one served comes back later.
    $display("[TB] contention");
    applyStimulus(4'b1111);
    g0 = rrPick(req, expPtr);
    serveOne("cont1");
    serveOne("cont2");
    req[g0] = 1'b1;
    serveOne("cont3");
    serveOne("cont4");
    serveOne("cont5");

    // Random request mixes, drained to empty.
    $display("[TB] random requests");
    repeat (8) begin
      if (req == '0) applyStimulus(4'($urandom_range(1, 15)));
      else           req = req | 4'($urandom_range(0, 15));
      serveOne("rand");
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req != '0) serveOne("drain");
    end

    // Abort after three copied elements.
    $display("[TB] abort");
    k = expPtr;
    for (int i = 0; i < DEPTH; i++) srcMem[k][i] = expCopied[i] ^ 4'hF;
    oneHot    = '0;
    oneHot[k] = 1'b1;
    applyStimulus(oneHot);
    repeat (4) @(negedge clk);
    req[k] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) expCopied[i] = srcMem[k][i];
    checkOutput("abort_pulse",  64'(abort),  64'(oneHot));
    checkOutput("abort_done",   64'(done),   64'(0));
    checkOutput("abort_gnt",    64'(gnt),    64'(0));
    checkOutput("abort_busy",   64'(busy),   64'(0));
    checkOutput("abort_copied", 64'(copied), 64'(packCopied()));
    @(negedge clk);
    checkOutput("abort_oneCycle", 64'(abort), 64'(0));
    expPtr = (k + 1) % NUM_REQ;
    randomizeSrc(k);

    // X/Z bits on a source element are copied unchanged.
    $display("[TB] x propagation");
    k    = expPtr;
    xVal = 4'bxx01;
    srcMem[k][2] = xVal;
    oneHot    = '0;
    oneHot[k] = 1'b1;
    applyStimulus(oneHot);
    serveOne("xprop");
    checkOutput("xprop_elem2", 64'(copied[2*WIDTH +: WIDTH]), 64'(xVal));

    // Asynchronous reset in the middle of a copy.
    $display("[TB] reset mid-copy");
    k         = NUM_REQ - 1;
    oneHot    = '0;
    oneHot[k] = 1'b1;
    applyStimulus(oneHot);
    repeat (3) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midrst_gnt",    64'(gnt),    64'(0));
    checkOutput("midrst_rdIdx",  64'(rdIdx),  64'(0));
    checkOutput("midrst_busy",   64'(busy),   64'(0));
    checkOutput("midrst_copied", 64'(copied), 64'(0));
    checkOutput("midrst_done",   64'(done),   64'(0));
    checkOutput("midrst_abort",  64'(abort),  64'(0));
    checkOutput("midrst_err",    64'(err),    64'(0));
    for (int i = 0; i < DEPTH; i++) expCopied[i] = '0;
    expPtr = 0;
    @(negedge clk);
    applyStimulus(oneHot | 4'b0001);
    rstN = 1'b1;
    serveOne("postrst0");
    serveOne("postrst1");

    // Source changed after the copy: flagged only with the verify pass.
    $display("[TB] source change after copy");
    k         = expPtr;
    oneHot    = '0;
    oneHot[k] = 1'b1;
    for (int i = 0; i < DEPTH; i++) expCopied[i] = srcMem[k][i];
    applyStimulus(oneHot);
    repeat (7) @(negedge clk);
    srcMem[k][4] = ~srcMem[k][4];
    waitEvent(cyc, fg);
    checkOutput("vfy_lat",    64'(cyc + 7), 64'(LAT));
    checkOutput("vfy_done",   64'(done),    64'(oneHot));
    checkOutput("vfy_err",    64'(err),     64'(EXP_ERR));
    checkOutput("vfy_copied", 64'(copied),  64'(packCopied()));
    req[k] = 1'b0;
    expPtr = (k + 1) % NUM_REQ;
    randomizeSrc(k);
    @(negedge clk);
    checkOutput("vfy_errSticky", 64'(err), 64'(EXP_ERR));

    // A clean transfer afterwards clears err on its grant.
    oneHot         = '0;
    oneHot[expPtr] = 1'b1;
    applyStimulus(oneHot);
    serveOne("postvfy");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
